seg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for an N-digit common-anode 7-segment display.

---
 rtl/seg_scan_ctrl_pkg.sv | 11 +
 rtl/seg_scan_ctrl_if.sv | 22 ++
 rtl/seg_scan_ctrl_hex_to_7seg.sv | 28 ++
 rtl/seg_scan_ctrl.sv | 125 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg_scan_ctrl_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SCAN  = 1'b1
  } state_t;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Load handshake plus display pins of the scan controller, grouped as one bundle.
interface seg_scan_ctrl_if #(
  parameter int N_DIGITS = 4
);
  logic                    load_valid;
  logic                    load_ready;
  logic [4*N_DIGITS-1:0]   load_data;
  logic                    blank_en;
  logic [6:0]              seg;
  logic [N_DIGITS-1:0]     an;
  logic                    frame_end;

  modport master (
    output load_valid, load_data, blank_en,
    input  load_ready, seg, an, frame_end
  );

  modport slave (
    input  load_valid, load_data, blank_en,
    output load_ready, seg, an, frame_end
  );
endinterface

// File: rtl/seg_scan_ctrl_hex_to_7seg.sv
// Hex nibble to active-low {g,f,e,d,c,b,a} segment pattern; purely combinational.
module seg_scan_ctrl_hex_to_7seg (
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);
  always_comb begin
    o_seg = 7'h7F;
    case (i_nib)
      4'h0: o_seg = 7'h40;
      4'h1: o_seg = 7'h79;
      4'h2: o_seg = 7'h24;
      4'h3: o_seg = 7'h30;
      4'h4: o_seg = 7'h19;
      4'h5: o_seg = 7'h12;
      4'h6: o_seg = 7'h02;
      4'h7: o_seg = 7'h78;
      4'h8: o_seg = 7'h00;
      4'h9: o_seg = 7'h10;
      4'hA: o_seg = 7'h08;
      4'hB: o_seg = 7'h03;
      4'hC: o_seg = 7'h46;
      4'hD: o_seg = 7'h21;
      4'hE: o_seg = 7'h06;
      4'hF: o_seg = 7'h0E;
      default: o_seg = 7'h7F;
    endcase
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// N-digit multiplexed 7-seg scanner; seg/an lag the digit index by one cycle.
// Single-entry pending buffer: load_ready drops while full, reopens on the frame commit edge.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int DIV      = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  seg_scan_ctrl_if.slave scan_if
);
  localparam int TW = $clog2(DIV);
  localparam int IW = $clog2(N_DIGITS);
  localparam int DW = 4 * N_DIGITS;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);

  state_t                r_state, w_state_next;
  logic [TW-1:0]         r_tick;
  logic [IW-1:0]         r_idx;
  logic [DW-1:0]         r_pend, r_disp;
  logic                  r_pend_full;
  logic                  r_frame_end;
  logic [6:0]            r_seg, w_seg_d, w_dec_seg;
  logic [N_DIGITS-1:0]   r_an, w_an_d, w_lit;
  logic                  w_nz_acc;
  logic                  w_tick_last, w_frame_last, w_commit, w_load_ready, w_accept;
  logic [3:0]            w_nib;

  assign w_tick_last  = (r_tick == TICK_LAST);
  assign w_frame_last = w_tick_last && (r_idx == IDX_LAST);
  // Commit happens on the same edge that raises frame_end, freeing the slot for a same-edge accept.
  assign w_commit     = w_frame_last && r_pend_full;
  assign w_load_ready = !r_pend_full || w_commit;
  assign w_accept     = scan_if.load_valid && w_load_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick      <= '0;
      r_idx       <= '0;
      r_frame_end <= 1'b0;
    end else begin
      r_frame_end <= w_frame_last;
      if (w_tick_last) begin
        r_tick <= '0;
        r_idx  <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_tick <= r_tick + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend      <= '0;
      r_pend_full <= 1'b0;
      r_disp      <= '0;
    end else begin
      if (w_commit) r_disp <= r_pend;
      if (w_accept) begin
        r_pend      <= scan_if.load_data;
        r_pend_full <= 1'b1;
      end else if (w_commit) begin
        r_pend_full <= 1'b0;
      end
    end
  end

  // A digit stays lit if it or any more-significant nibble is non-zero; digit 0 always lit.
  always_comb begin
    w_lit    = '0;
    w_nz_acc = 1'b0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      w_nz_acc = w_nz_acc | (r_disp[4*i +: 4] != 4'h0);
      w_lit[i] = w_nz_acc || (i == 0) || !BLANK_LZ;
    end
  end

  assign w_nib = r_disp[{r_idx, 2'b00} +: 4];

  seg_scan_ctrl_hex_to_7seg u_dec (
    .i_nib (w_nib),
    .o_seg (w_dec_seg)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_BLANK;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_seg_d      = SEG_BLANK;
    w_an_d       = '1;
    case (r_state)
      ST_BLANK: begin
        if (w_commit) w_state_next = ST_SCAN;
      end
      ST_SCAN: begin
        if (!scan_if.blank_en && w_lit[r_idx]) begin
          w_seg_d       = w_dec_seg;
          w_an_d[r_idx] = 1'b0;
        end
      end
      default: w_state_next = ST_BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_seg <= SEG_BLANK;
      r_an  <= '1;
    end else begin
      r_seg <= w_seg_d;
      r_an  <= w_an_d;
    end
  end

  assign scan_if.load_ready = w_load_ready;
  assign scan_if.seg        = r_seg;
  assign scan_if.an         = r_an;
  assign scan_if.frame_end  = r_frame_end;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench: two instances (leading-zero blanking on/off) share one stimulus stream.
module tb_seg_scan_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic [15:0] load_data;
  logic        blank_en;
  int          checks = 0;
  int          errors = 0;

  localparam logic [3:0][3:0] AN_ALL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  always #5 clk = ~clk;

  seg_scan_ctrl_if #(.N_DIGITS(4)) if0 ();
  seg_scan_ctrl_if #(.N_DIGITS(4)) if1 ();

  assign if0.load_valid = load_valid;
  assign if0.load_data  = load_data;
  assign if0.blank_en   = blank_en;
  assign if1.load_valid = load_valid;
  assign if1.load_data  = load_data;
  assign if1.blank_en   = blank_en;

  seg_scan_ctrl #(.N_DIGITS(4), .DIV(4), .BLANK_LZ(1'b1)) u_dut0 (
    .clk(clk), .reset(reset), .scan_if(if0)
  );
  seg_scan_ctrl #(.N_DIGITS(4), .DIV(4), .BLANK_LZ(1'b0)) u_dut1 (
    .clk(clk), .reset(reset), .scan_if(if1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Dark outputs for n cycles after a reset release; frame_end every 16th cycle.
  task automatic check_dark(input string tag, input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      chk({tag, "_seg"}, 32'(if0.seg), 32'h7F);
      chk({tag, "_an"},  32'(if0.an),  32'hF);
      chk({tag, "_fe"},  32'(if0.frame_end), ((k % 16) == 0) ? 32'd1 : 32'd0);
    end
  endtask

  // Caller sits on the negedge where frame_end is high; checks the next full frame.
  task automatic expect_frame(input string tag,
                              input logic [3:0][6:0] s0, input logic [3:0][3:0] a0,
                              input logic [3:0][6:0] s1, input logic [3:0][3:0] a1);
    for (int d = 0; d < 4; d++) begin
      for (int t = 0; t < 4; t++) begin
        @(negedge clk);
        chk({tag, "_seg0"}, 32'(if0.seg), 32'(s0[d]));
        chk({tag, "_an0"},  32'(if0.an),  32'(a0[d]));
        chk({tag, "_seg1"}, 32'(if1.seg), 32'(s1[d]));
        chk({tag, "_an1"},  32'(if1.an),  32'(a1[d]));
        chk({tag, "_fe"},   32'(if0.frame_end), (d == 3 && t == 3) ? 32'd1 : 32'd0);
      end
    end
  endtask

  task automatic wait_fe(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if0.frame_end && n < 40);
    chk(tag, 32'(if0.frame_end), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    blank_en   = 1'b0;

    // Reset values
    repeat (3) begin
      @(negedge clk);
      chk("rst_seg", 32'(if0.seg), 32'h7F);
      chk("rst_an",  32'(if0.an),  32'hF);
      chk("rst_rdy", 32'(if0.load_ready), 32'd1);
      chk("rst_fe",  32'(if0.frame_end), 32'd0);
    end
    reset = 1'b0;

    // 1: idle after reset
    check_dark("idle", 40);

    // 2: load 1A3F mid-frame (tick 0, idx 2)
    load_valid = 1'b1;
    load_data  = 16'h1A3F;
    @(negedge clk);
    chk("t2_rdy_after_acc", 32'(if0.load_ready), 32'd0);
    load_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("t2_rdy_hold", 32'(if0.load_ready), 32'd0);
    end
    @(negedge clk);
    chk("t2_rdy_commit", 32'(if0.load_ready), 32'd1);
    @(negedge clk);
    chk("t2_fe", 32'(if0.frame_end), 32'd1);
    chk("t2_seg_dark", 32'(if0.seg), 32'h7F);
    chk("t2_rdy_empty", 32'(if0.load_ready), 32'd1);
    expect_frame("t2", {7'h79, 7'h08, 7'h30, 7'h0E}, AN_ALL,
                       {7'h79, 7'h08, 7'h30, 7'h0E}, AN_ALL);

    // 3: load 0007, blanking on (dut0) vs off (dut1)
    load_valid = 1'b1;
    load_data  = 16'h0007;
    @(negedge clk);
    load_valid = 1'b0;
    wait_fe("t3_fe");
    expect_frame("t3", {7'h7F, 7'h7F, 7'h7F, 7'h78}, {4'hF, 4'hF, 4'hF, 4'b1110},
                       {7'h40, 7'h40, 7'h40, 7'h78}, AN_ALL);

    // 4: back-to-back 1111 then 2222
    load_valid = 1'b1;
    load_data  = 16'h1111;
    @(negedge clk);
    chk("t4_rdy_full", 32'(if0.load_ready), 32'd0);
    load_data = 16'h2222;
    @(negedge clk);
    chk("t4_rdy_wait", 32'(if0.load_ready), 32'd0);
    wait_fe("t4_fe");
    chk("t4_rdy_refill", 32'(if0.load_ready), 32'd0);
    load_valid = 1'b0;
    expect_frame("t4a", {4{7'h79}}, AN_ALL, {4{7'h79}}, AN_ALL);
    chk("t4_rdy_drained", 32'(if0.load_ready), 32'd1);
    expect_frame("t4b", {4{7'h24}}, AN_ALL, {4{7'h24}}, AN_ALL);

    // 5: blank_en for 10 cycles during SCAN
    blank_en = 1'b1;
    for (int r = 1; r <= 16; r++) begin
      @(negedge clk);
      if (r == 10) blank_en = 1'b0;
      chk("t5_seg", 32'(if0.seg), (r <= 10) ? 32'h7F : 32'h24);
      chk("t5_an",  32'(if0.an),  (r <= 10) ? 32'hF  : 32'(AN_ALL[(r - 1) / 4]));
      chk("t5_fe",  32'(if0.frame_end), (r == 16) ? 32'd1 : 32'd0);
    end

    // 6: reset mid-frame with pending full
    load_valid = 1'b1;
    load_data  = 16'h3333;
    @(negedge clk);
    load_valid = 1'b0;
    chk("t6_rdy_full", 32'(if0.load_ready), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_seg", 32'(if0.seg), 32'h7F);
    chk("t6_an",  32'(if0.an),  32'hF);
    chk("t6_fe",  32'(if0.frame_end), 32'd0);
    chk("t6_rdy", 32'(if0.load_ready), 32'd1);
    reset = 1'b0;
    check_dark("t6_after", 40);
    chk("t6_rdy_end", 32'(if0.load_ready), 32'd1);
    chk("t6_an1_end", 32'(if1.an), 32'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
